// File: rtl/muldiv_unit_if.sv
// Register-file side handshake of the iterative multiply/divide unit.
`timescale 1ns/1ps
interface muldiv_unit_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  operandA;
    logic [WIDTH-1:0]  operandB;
    logic [ADDR_W-1:0] destAddress;
    logic              flush;
    logic              busy;
    logic              writeRegister;
    logic [ADDR_W-1:0] writeAddress;
    logic [WIDTH-1:0]  writeData;

    // Control / operand side (drives requests, receives write-back)
    modport master (
        output start, op, operandA, operandB, destAddress, flush,
        input  busy, writeRegister, writeAddress, writeData
    );

    // Execution unit side
    modport slave (
        input  start, op, operandA, operandB, destAddress, flush,
        output busy, writeRegister, writeAddress, writeData
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide
// step per clock, result written back through the register file write port.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  b_q;
    logic [ADDR_W-1:0] dest_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  hi_d;
    logic [WIDTH-1:0]  lo_d;
    logic              busy_q;
    logic              wr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [WIDTH-1:0]  wdata_q;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_sub;
    logic [WIDTH-1:0]  result_c;

    // One iteration: hi/lo hold {product} for multiply, {remainder, quotient} for divide
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        // Difference fits in WIDTH bits whenever it is kept (it is below the divisor)
        div_sub   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} - b_q;
        if (!op_q[1]) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // MUL/DIVU take the low half (product low / quotient), MULHU/REMU the high half
    assign result_c = op_q[0] ? hi_q : lo_q;

    // Control FSM, operand latches, accumulators and write-back registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            dest_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_q <= 1'b0;
                    if (bus.start && !bus.flush) begin
                        op_q    <= bus.op;
                        b_q     <= bus.operandB;
                        dest_q  <= bus.destAddress;
                        hi_q    <= '0;
                        lo_q    <= bus.operandA;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_W'(WIDTH)) begin
                        // All iterations done: present the result for one cycle
                        wdata_q <= result_c;
                        waddr_q <= dest_q;
                        wr_q    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the write cycle must kill the strobe in that same cycle
    assign bus.writeRegister = wr_q & ~bus.flush;
    assign bus.busy          = busy_q;
    assign bus.writeAddress  = waddr_q;
    assign bus.writeData     = wdata_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle compare.
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    muldiv_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    muldiv_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: one outstanding operation at most
    longint      cyc      = 0;
    logic        pend     = 1'b0;
    longint      acc_cyc  = 0;
    logic [31:0] exp_data = '0;
    logic [4:0]  exp_addr = '0;
    logic        exp_wr;

    // Observed write-backs
    int          wr_count  = 0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_addr = '0;
    longint      last_cyc  = 0;

    function automatic logic [31:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: accept when idle, retire 34 edges after acceptance or on flush
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (pend) begin
                if (bus.flush || cyc == acc_cyc + 33) pend <= 1'b0;
            end else if (bus.start && !bus.flush) begin
                pend     <= 1'b1;
                acc_cyc  <= cyc + 1;
                exp_data <= ref_result(bus.op, bus.operandA, bus.operandB);
                exp_addr <= bus.destAddress;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clock) begin
        if (reset) begin
            exp_wr = pend && (cyc == acc_cyc + 33) && !bus.flush;
            check("busy", 64'(bus.busy), 64'(pend));
            check("writeRegister", 64'(bus.writeRegister), 64'(exp_wr));
            if (exp_wr) begin
                check("writeData", 64'(bus.writeData), 64'(exp_data));
                check("writeAddress", 64'(bus.writeAddress), 64'(exp_addr));
            end
            if (bus.writeRegister) begin
                wr_count++;
                last_data = bus.writeData;
                last_addr = bus.writeAddress;
                last_cyc  = cyc;
            end
        end
    end

    // Present a one-cycle start; acc is the model cycle index of the accept edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, output longint acc);
        @(posedge clock); #1;
        bus.start = 1'b1; bus.op = op; bus.operandA = a; bus.operandB = b; bus.destAddress = d;
        @(posedge clock); #1;
        acc = cyc;
        bus.start = 1'b0;
        bus.operandA = $urandom; bus.operandB = $urandom; bus.destAddress = 5'($urandom);
        bus.op = 2'($urandom);
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
        int     n0;
        longint acc;
        n0 = wr_count;
        issue(op, a, b, d, acc);
        repeat (40) @(posedge clock);
        #1;
        check({name, "_writes"}, 64'(wr_count - n0), 64'd1);
        check({name, "_data"}, 64'(last_data), 64'(exp));
        check({name, "_addr"}, 64'(last_addr), 64'(d));
        check({name, "_latency"}, 64'(last_cyc - acc), 64'd33);
        check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        longint acc;
        int     n0;
        bus.start = 1'b0; bus.op = 2'd0; bus.operandA = '0; bus.operandB = '0;
        bus.destAddress = '0; bus.flush = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_wr", 64'(bus.writeRegister), 64'd0);
        check("rst_data", 64'(bus.writeData), 64'd0);
        check("rst_addr", 64'(bus.writeAddress), 64'd0);
        reset = 1'b1;

        // Pin the reference model to hand-computed values
        check("model_mulhu", 64'(ref_result(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
        check("model_div0", 64'(ref_result(2'd2, 32'd55, 32'd0)), 64'hFFFF_FFFF);
        check("model_rem0", 64'(ref_result(2'd3, 32'd55, 32'd0)), 64'd55);

        directed("mul7x6", 2'd0, 32'd7, 32'd6, 5'd3, 32'd42);
        directed("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        directed("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
        directed("divu100_7", 2'd2, 32'd100, 32'd7, 5'd5, 32'd14);
        directed("remu100_7", 2'd3, 32'd100, 32'd7, 5'd6, 32'd2);
        directed("divu_msb", 2'd2, 32'h8000_0000, 32'd1, 5'd7, 32'h8000_0000);
        directed("divu_by0", 2'd2, 32'd55, 32'd0, 5'd8, 32'hFFFF_FFFF);
        directed("remu_by0", 2'd3, 32'd55, 32'd0, 5'd9, 32'd55);

        // Start while busy is ignored
        n0 = wr_count;
        issue(2'd2, 32'd100, 32'd7, 5'd4, acc);
        repeat (9) @(posedge clock);
        #1;
        bus.start = 1'b1; bus.op = 2'd0; bus.operandA = 32'd2; bus.operandB = 32'd2;
        bus.destAddress = 5'd9;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (35) @(posedge clock);
        #1;
        check("busy_start_writes", 64'(wr_count - n0), 64'd1);
        check("busy_start_data", 64'(last_data), 64'd14);
        check("busy_start_addr", 64'(last_addr), 64'd4);

        // Flush mid-run: no write-back, busy drops after the next edge
        n0 = wr_count;
        issue(2'd0, 32'd9, 32'd9, 5'd6, acc);
        repeat (19) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        repeat (20) @(posedge clock);
        #1;
        check("flush_writes", 64'(wr_count - n0), 64'd0);

        // Asynchronous reset between edges mid-run
        n0 = wr_count;
        issue(2'd0, 32'd5, 32'd5, 5'd10, acc);
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_wr", 64'(bus.writeRegister), 64'd0);
        check("arst_data", 64'(bus.writeData), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("arst_no_write", 64'(wr_count - n0), 64'd0);
        directed("mul3x5", 2'd0, 32'd3, 32'd5, 5'd11, 32'd15);

        // Randomized traffic, including flushes, zero divisors and busy-time starts
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock); #1;
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.flush       = ($urandom_range(0, 59) == 0);
            bus.op          = 2'($urandom);
            bus.destAddress = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       bus.operandA = 32'($urandom_range(0, 255));
                default: bus.operandA = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       bus.operandB = 32'd0;
                1:       bus.operandB = 32'($urandom_range(1, 15));
                default: bus.operandB = $urandom;
            endcase
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (40) @(posedge clock);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
